// File: rtl/bbc_clk_pkg.sv
// Shared clock-domain definitions for the 1 MHz stretch logic: FSM encoding
// and phase constants derived from the divider width.
package bbc_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SYNC  = 2'd2
  } state_t;

  localparam int DIV_LOG2_DEFAULT  = 5;
  localparam int HALF_DEFAULT      = 1 << (DIV_LOG2_DEFAULT - 1);
  localparam int END_PHASE_DEFAULT = (1 << DIV_LOG2_DEFAULT) - 1;

  function automatic int half_phase(input int log2);
    return 1 << (log2 - 1);
  endfunction

  function automatic int end_phase(input int log2);
    return (1 << log2) - 1;
  endfunction

endpackage

// File: rtl/bbc_phase_div.sv
// Free-running divider phase counter with a registered enable on the last
// clock of each 1 MHz period.
module bbc_phase_div
  import bbc_clk_pkg::*;
#(
  parameter int DIV_LOG2 = DIV_LOG2_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [DIV_LOG2-1:0] o_phase,
  output logic [DIV_LOG2-1:0] o_phase_nxt,
  output logic                o_mhz1_clken
);

  localparam logic [DIV_LOG2-1:0] P_ONE = DIV_LOG2'(1);
  localparam logic [DIV_LOG2-1:0] P_END = DIV_LOG2'(end_phase(DIV_LOG2));

  logic [DIV_LOG2-1:0] r_phase;
  logic [DIV_LOG2-1:0] w_phase_nxt;
  logic                r_mhz1_clken;

  assign w_phase_nxt = r_phase + P_ONE;

  // Enable is registered from the next phase so it coincides with phase == END.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase      <= '0;
      r_mhz1_clken <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_mhz1_clken <= (w_phase_nxt == P_END);
    end
  end

  assign o_phase      = r_phase;
  assign o_phase_nxt  = w_phase_nxt;
  assign o_mhz1_clken = r_mhz1_clken;

endmodule

// File: rtl/mhz1_stretch.sv
// 2 MHz CPU clock-enable generator that stretches cycles touching 1 MHz
// peripherals. Stretching is built only when MHZ1_STRETCH_EN is defined.
module mhz1_stretch
  import bbc_clk_pkg::*;
#(
  parameter int DIV_LOG2 = DIV_LOG2_DEFAULT
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                mhz1_enable,
  output logic                cpu_clken,
  output logic                mhz1_clken,
  output logic                stall,
  output logic [DIV_LOG2-1:0] div_phase
);

  localparam logic [DIV_LOG2-1:0] P_END = DIV_LOG2'(end_phase(DIV_LOG2));

  logic [DIV_LOG2-1:0] w_phase_nxt;
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_cpu_clken;
  logic                w_clken_nxt;

  bbc_phase_div #(.DIV_LOG2(DIV_LOG2)) u_div (
    .i_clk        (CLOCK),
    .i_rst        (RESET),
    .o_phase      (div_phase),
    .o_phase_nxt  (w_phase_nxt),
    .o_mhz1_clken (mhz1_clken)
  );

`ifdef MHZ1_STRETCH_EN
  logic w_cyc_start;
  logic r_stall;

  assign w_cyc_start = (r_state == IDLE) && (div_phase[DIV_LOG2-2:0] == '0);

  // Enable is sampled only at IDLE cycle starts; the top phase bit says
  // whether the start is on the 1 MHz boundary (SYNC) or half-way (ALIGN).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cyc_start && mhz1_enable)
                 w_state_nxt = div_phase[DIV_LOG2-1] ? ALIGN : SYNC;
      ALIGN:   if (div_phase == P_END) w_state_nxt = SYNC;
      SYNC:    if (div_phase == P_END) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_stall <= 1'b0;
    else       r_stall <= (w_state_nxt != IDLE);
  end

  assign stall = r_stall;
`else
  logic w_unused_en;

  assign w_unused_en = mhz1_enable;
  assign w_state_nxt = IDLE;
  assign stall       = 1'b0;
`endif

  // Half-period ends only complete a cycle in IDLE; a stretched cycle ends
  // solely at the close of SYNC.
  assign w_clken_nxt =
      ((w_state_nxt == IDLE) && (w_phase_nxt[DIV_LOG2-2:0] == '1)) ||
      ((w_state_nxt == SYNC) && (w_phase_nxt == P_END));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cpu_clken <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_clken <= w_clken_nxt;
    end
  end

  assign cpu_clken = r_cpu_clken;

endmodule

// File: tb/tb_mhz1_stretch.sv
// Randomized bench for mhz1_stretch against a cycle-length reference model.
module tb_mhz1_stretch;
  import bbc_clk_pkg::*;

  localparam int L = DIV_LOG2_DEFAULT;
  localparam int N = 1 << L;
  localparam int H = N / 2;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         mhz1_enable;
  logic         cpu_clken;
  logic         mhz1_clken;
  logic         stall;
  logic [L-1:0] div_phase;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: clocks since reset, and the current CPU cycle's
  // remaining length / position / kind.
  int m_clk, m_left, m_pos;
  bit m_str, m_from_h;
  bit did_align_rst = 1'b0;
  int force_off = 0;

  mhz1_stretch #(.DIV_LOG2(L)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .mhz1_enable (mhz1_enable),
    .cpu_clken   (cpu_clken),
    .mhz1_clken  (mhz1_clken),
    .stall       (stall),
    .div_phase   (div_phase)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t clk=%0d)", tag, got, exp, $time, m_clk);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase"},  32'(div_phase), 0);
    chk({tag, "_cpu"},    32'(cpu_clken), 0);
    chk({tag, "_mhz1"},   32'(mhz1_clken), 0);
    chk({tag, "_stall"},  32'(stall), 0);
  endtask

  task automatic model_reset();
    m_clk = 0; m_left = 0; m_pos = 0; m_str = 1'b0; m_from_h = 1'b0;
  endtask

  // Called once per clock, #1 after the edge, with mhz1_enable already set.
  task automatic clock_body();
    int ph;
    ph = m_clk % N;
    if (m_left == 0) begin
      m_pos = 0;
`ifdef MHZ1_STRETCH_EN
      m_str = mhz1_enable;
`else
      m_str = 1'b0;
`endif
      m_from_h = (ph != 0);
      m_left   = !m_str ? H : (ph == 0 ? N : N + H);
    end
    chk("div_phase",  32'(div_phase),  ph);
    chk("cpu_clken",  32'(cpu_clken),  (m_left == 1) ? 1 : 0);
    chk("stall",      32'(stall),      (m_str && m_pos > 0) ? 1 : 0);
    chk("mhz1_clken", 32'(mhz1_clken), (ph == N - 1) ? 1 : 0);
    m_left--; m_pos++; m_clk++;
  endtask

  task automatic do_reset(input string tag);
    RESET = 1'b1;
    #1;
    chk_zero({tag, "_async"});
    @(posedge CLOCK); #1;
    chk_zero({tag, "_held"});
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    int mode;
    RESET = 1'b1;
    mhz1_enable = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    chk_zero("reset");
    RESET = 1'b0;
    model_reset();

    for (int k = 0; k < 6000; k++) begin
      if (k > 0) begin
        @(posedge CLOCK); #1;
      end
      mode = (k < 200) ? 2 : ((k / 200) % 4);
      case (mode)
        0:       mhz1_enable = 1'($urandom_range(0, 1));
        1:       mhz1_enable = 1'b1;
        2:       mhz1_enable = 1'b0;
        default: mhz1_enable = ($urandom_range(0, 7) == 0);
      endcase
      if (force_off > 0) begin
        mhz1_enable = 1'b0;
        force_off--;
      end
      // Abort a half-period-aligned stretch four clocks in (phase 20).
      if (!did_align_rst && m_left > 0 && m_str && m_from_h && m_pos == 4) begin
        did_align_rst = 1'b1;
        do_reset("align_rst");
        mhz1_enable = 1'b0;
        force_off   = H;
      end else if (k > 200 && $urandom_range(0, 999) == 0) begin
        do_reset("rand_rst");
      end
      clock_body();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
